// File: rtl/adc_clock_gen.sv
// Programmable ADC sample-clock divider with rise/fall strobes.
// The ratio can be reloaded at runtime and takes effect only at a period boundary.
module adc_clock_gen #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_data,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_adc,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div,
  output logic [CNT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
  localparam logic [DIV_W:0]   ONE_X   = (DIV_W+1)'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_adc_q, clk_adc_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  logic             wrap;
  logic             accept;
  logic             apply;
  logic             active_d;
  logic [DIV_W:0]   half_d;

  assign wrap   = (state_q != IDLE) &&
                  (cnt_q == cur_div_q - ONE);
  assign accept = div_valid && !pend_vld_q;
  assign apply  = pend_vld_q &&
                  ((state_q == IDLE) || wrap);

  // Next state and phase counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN, STOPPING: begin
        if (wrap) begin
          cnt_d   = '0;
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = en ? RUN : STOPPING;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Ratio handshake: one pending slot, clamped at capture
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cur_div_d  = cur_div_q;
    if (accept) begin
      pend_d     = (div_data < TWO) ? TWO : div_data;
      pend_vld_d = 1'b1;
    end else if (apply) begin
      cur_div_d  = pend_q;
      pend_vld_d = 1'b0;
    end
  end

  // Outputs are decoded from next-cycle values so they register together
  always_comb begin
    active_d   = (state_d != IDLE);
    half_d     = ({1'b0, cur_div_d} + ONE_X) >> 1;
    clk_adc_d  = active_d && ({1'b0, cnt_d} < half_d);
    rise_d     = active_d && (cnt_d == '0);
    fall_d     = active_d && ({1'b0, cnt_d} == half_d);
    edge_cnt_d = edge_cnt_q + CNT_W'(rise_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DEF_DIV;
      pend_q     <= DEF_DIV;
      pend_vld_q <= 1'b0;
      clk_adc_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_adc_q  <= clk_adc_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign div_ready = !pend_vld_q;
  assign clk_adc   = clk_adc_q;
  assign rise_stb  = rise_q;
  assign fall_stb  = fall_q;
  assign busy      = (state_q != IDLE);
  assign cur_div   = cur_div_q;
  assign edge_cnt  = edge_cnt_q;

endmodule
